// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern-mode encoding, colour-bar table and
// raster-total helpers used by the timing core and the pattern generator.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  localparam int unsigned BAR_COUNT = 8;

  // {R,G,B} on/off masks; index 0 (white) is the leftmost bar, 7 is black.
  localparam logic [BAR_COUNT-1:0][2:0] BAR_MASK = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing core: h/v counters, sync/de decode and line/frame markers.
// Ports: clk, reset (sync, active-high), pix_en (clock enable);
//        hcnt/vcnt (live counters), active_c, line_last_c, frame_last_c
//        (combinational decode of the live counters);
//        hsync, vsync, de, x, y, line_start, frame_start (registered, one
//        enabled cycle behind the counters).
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active_c,
  output logic             line_last_c,
  output logic             frame_last_c,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic v_last_c;
  logic hs_act_c;
  logic vs_act_c;

  // Decode of the current counter position.
  always_comb begin
    line_last_c  = (hcnt == CNT_W'(H_TOTAL - 1));
    v_last_c     = (vcnt == CNT_W'(V_TOTAL - 1));
    frame_last_c = line_last_c && v_last_c;
    active_c     = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    hs_act_c     = (hcnt >= CNT_W'(HS_START)) && (hcnt < CNT_W'(HS_END));
    vs_act_c     = (vcnt >= CNT_W'(VS_START)) && (vcnt < CNT_W'(VS_END));
  end

  // Counters plus registered copies of the decode for the pixel just counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hsync       <= hs_act_c ? H_POL : ~H_POL;
      vsync       <= vs_act_c ? V_POL : ~V_POL;
      de          <= active_c;
      x           <= hcnt;
      y           <= vcnt;
      line_start  <= (hcnt == '0);
      frame_start <= (hcnt == '0) && (vcnt == '0);
      hcnt        <= line_last_c ? '0 : hcnt + CNT_W'(1);
      if (line_last_c) begin
        vcnt <= v_last_c ? '0 : vcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing plus test-pattern generator: drives sync, data-enable, pixel
// coordinates and COLOR_W-bit RGB (solid / colour bars / checker / gradient).
// Ports: pixelClk, reset (sync, active-high), pixEn (clock enable),
//        mode (pattern select, applied at frame boundaries), solidRGB {R,G,B};
//        hsync, vsync, de, xCor, yCor, lineStart, frameStart, VGA_R/G/B.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned BAR_W      = 80,
  parameter int unsigned CHK_LOG2   = 5,
  parameter int unsigned GRAD_SHIFT = 4
) (
  input  logic                 pixelClk,
  input  logic                 reset,
  input  logic                 pixEn,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solidRGB,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CNT_W-1:0]     xCor,
  output logic [CNT_W-1:0]     yCor,
  output logic                 lineStart,
  output logic                 frameStart,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B
);

  localparam int unsigned RGB_W = 3 * COLOR_W;

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             active_c;
  logic             line_last_c;
  logic             frame_last_c;
  mode_e            mode_q;
  logic [2:0]       bar_idx;
  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar_mask_c;
  logic [RGB_W-1:0] rgb_c;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_POL    (H_POL),
    .V_POL    (V_POL),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clk          (pixelClk),
    .reset        (reset),
    .pix_en       (pixEn),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .active_c     (active_c),
    .line_last_c  (line_last_c),
    .frame_last_c (frame_last_c),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .x            (xCor),
    .y            (yCor),
    .line_start   (lineStart),
    .frame_start  (frameStart)
  );

  // Mode shadow: only reloaded on the last pixel so a frame never tears.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      mode_q <= MODE_SOLID;
    end else if (pixEn && frame_last_c) begin
      mode_q <= mode_e'(mode);
    end
  end

  // Bar tracker for the pixel at hcnt; restarts every line, sticks at black.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if (pixEn) begin
      if (line_last_c) begin
        bar_idx <= '0;
        bar_cnt <= '0;
      end else if (bar_cnt == CNT_W'(BAR_W - 1)) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) begin
          bar_idx <= bar_idx + 3'd1;
        end
      end else begin
        bar_cnt <= bar_cnt + CNT_W'(1);
      end
    end
  end

  // Pattern mux for the current counter position; blanking forces black.
  always_comb begin
    rgb_c      = '0;
    bar_mask_c = BAR_MASK[bar_idx];
    if (active_c) begin
      case (mode_q)
        MODE_SOLID: rgb_c = solidRGB;
        MODE_BARS:  rgb_c = {{COLOR_W{bar_mask_c[2]}}, {COLOR_W{bar_mask_c[1]}},
                             {COLOR_W{bar_mask_c[0]}}};
        MODE_CHECK: rgb_c = {RGB_W{hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]}};
        MODE_GRAD:  rgb_c = {3{hcnt[GRAD_SHIFT +: COLOR_W]}};
      endcase
    end
  end

  // Colour output register, aligned with the timing outputs.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (pixEn) begin
      {VGA_R, VGA_G, VGA_B} <= rgb_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Self-checking bench: two instances (tiny raster, and a medium raster with
// active-high syncs) run against a reference model via expected-output queues.
module tb_vga_timing_pattern_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } out_t;

  typedef struct {
    int hact; int hfp; int hs; int hbp;
    int vact; int vfp; int vs; int vbp;
    bit hpol; bit vpol;
    int barw; int chk; int grad;
  } cfg_t;

  typedef struct {
    int   h;
    int   v;
    int   md;
    out_t last;
  } mst_t;

  // Instance A: tiny raster 16x8 (128 clocks/frame)
  localparam int A_HA = 8,  A_HF = 2, A_HS = 3, A_HB = 3;
  localparam int A_VA = 4,  A_VF = 1, A_VS = 2, A_VB = 1;
  // Instance B: 56x36 raster (2016 clocks/frame), active-high syncs
  localparam int B_HA = 40, B_HF = 4, B_HS = 8, B_HB = 4;
  localparam int B_VA = 30, B_VF = 2, B_VS = 2, B_VB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, pix_en_a, reset_b, pix_en_b;
  logic [1:0] mode_a, mode_b;
  logic [11:0] solid_a, solid_b;
  logic       hs_a, vs_a, de_a, ls_a, fs_a, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  out_t       act_a, act_b;

  assign act_a = {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, r_a, g_a, b_a};
  assign act_b = {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b, r_b, g_b, b_b};

  vga_timing_pattern_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(4), .CNT_W(10),
    .BAR_W(1), .CHK_LOG2(1), .GRAD_SHIFT(0)
  ) dut_a (
    .pixelClk(clk), .reset(reset_a), .pixEn(pix_en_a), .mode(mode_a), .solidRGB(solid_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .xCor(x_a), .yCor(y_a),
    .lineStart(ls_a), .frameStart(fs_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(4), .CNT_W(10),
    .BAR_W(5), .CHK_LOG2(2), .GRAD_SHIFT(2)
  ) dut_b (
    .pixelClk(clk), .reset(reset_b), .pixEn(pix_en_b), .mode(mode_b), .solidRGB(solid_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .xCor(x_b), .yCor(y_b),
    .lineStart(ls_b), .frameStart(fs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  cfg_t cfg_a, cfg_b;
  mst_t st_a, st_b;
  out_t q_a[$];
  out_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic logic [11:0] bar_rgb(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic out_t reset_out(input cfg_t c);
    out_t o;
    o       = '0;
    o.hsync = ~c.hpol;
    o.vsync = ~c.vpol;
    return o;
  endfunction

  // Expected registered output for the pixel at counter (x, y).
  function automatic out_t model_pix(input cfg_t c, input int x, input int y, input int md,
                                     input logic [11:0] solid);
    out_t        o;
    int          idx;
    logic [3:0]  gv;
    logic [11:0] rgb;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.de    = (x < c.hact) && (y < c.vact);
    o.hsync = (x >= c.hact + c.hfp && x < c.hact + c.hfp + c.hs) ? c.hpol : ~c.hpol;
    o.vsync = (y >= c.vact + c.vfp && y < c.vact + c.vfp + c.vs) ? c.vpol : ~c.vpol;
    o.ls    = (x == 0);
    o.fs    = (x == 0) && (y == 0);
    rgb     = 12'h000;
    if (o.de) begin
      case (md)
        0: rgb = solid;
        1: begin
          idx = x / c.barw;
          if (idx > 7) idx = 7;
          rgb = bar_rgb(idx);
        end
        2: rgb = ((((x >> c.chk) ^ (y >> c.chk)) & 1) != 0) ? 12'hFFF : 12'h000;
        default: begin
          gv  = 4'((x >> c.grad) & 15);
          rgb = {gv, gv, gv};
        end
      endcase
    end
    {o.r, o.g, o.b} = rgb;
    return o;
  endfunction

  task automatic model_cycle(input cfg_t c, input bit rst, input bit en, input int mdin,
                             input logic [11:0] solid, inout mst_t s, output out_t e);
    int ht, vt;
    ht = c.hact + c.hfp + c.hs + c.hbp;
    vt = c.vact + c.vfp + c.vs + c.vbp;
    if (rst) begin
      s.h = 0; s.v = 0; s.md = 0;
      e = reset_out(c);
    end else if (en) begin
      e = model_pix(c, s.h, s.v, s.md, solid);
      if (s.h == ht - 1 && s.v == vt - 1) s.md = mdin;
      if (s.h == ht - 1) begin
        s.h = 0;
        s.v = (s.v == vt - 1) ? 0 : s.v + 1;
      end else begin
        s.h = s.h + 1;
      end
    end else begin
      e = s.last;
    end
    s.last = e;
  endtask

  // Drive one clock on both instances and queue the expected outputs.
  task automatic tick(input bit ra, input bit ea, input logic [1:0] ma,
                      input bit rb, input bit eb, input logic [1:0] mb);
    out_t e;
    reset_a = ra; pix_en_a = ea; mode_a = ma;
    reset_b = rb; pix_en_b = eb; mode_b = mb;
    model_cycle(cfg_a, ra, ea, int'(ma), solid_a, st_a, e);
    q_a.push_back(e);
    model_cycle(cfg_b, rb, eb, int'(mb), solid_b, st_b, e);
    q_b.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    out_t ea, eb;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      n_checks++;
      if (act_a !== ea) begin
        n_fail++;
        $display("FAIL reset_a cyc=%0d actual=%h expected=%h", cyc, act_a, ea);
      end
      n_checks++;
      if (act_b !== eb) begin
        n_fail++;
        $display("FAIL reset_b cyc=%0d actual=%h expected=%h", cyc, act_b, eb);
      end
    end
    n_checks++;
    if (hs_a !== 1'b1 || hs_b !== 1'b0 || vs_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_polarity actual=%b%b%b expected=100", hs_a, hs_b, vs_b);
    end
  endtask

  task automatic test_timing_a();
    out_t e;
    int hs_cnt = 0, vs_lines = 0, de_cnt = 0, nfs = 0, last_fs = -1;
    solid_a = 12'h7C1;
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    void'(q_a.pop_front());
    void'(q_b.pop_front());
    // Two full frames plus the first pixel of the third frame.
    for (int i = 0; i < 257; i++) begin
      tick(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
      e = q_a.pop_front();
      void'(q_b.pop_front());
      n_checks++;
      if (act_a !== e) begin
        n_fail++;
        $display("FAIL timing_a cyc=%0d actual=%h expected=%h", cyc, act_a, e);
      end
      if (!hs_a) hs_cnt++;
      if (!vs_a && ls_a) vs_lines++;
      if (de_a) de_cnt++;
      if (fs_a) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (cyc - last_fs != 128) begin
            n_fail++;
            $display("FAIL fs_period_a actual=%0d expected=128", cyc - last_fs);
          end
        end
        last_fs = cyc;
        nfs++;
      end
    end
    n_checks++;
    if (hs_cnt != 48) begin
      n_fail++; $display("FAIL hsync_count_a actual=%0d expected=48", hs_cnt);
    end
    n_checks++;
    if (vs_lines != 4) begin
      n_fail++; $display("FAIL vsync_lines_a actual=%0d expected=4", vs_lines);
    end
    n_checks++;
    if (de_cnt != 65) begin
      n_fail++; $display("FAIL de_count_a actual=%0d expected=65", de_cnt);
    end
    n_checks++;
    if (nfs != 3) begin
      n_fail++; $display("FAIL fs_count_a actual=%0d expected=3", nfs);
    end
  endtask

  task automatic test_bars_a();
    out_t        e;
    int          frame = 0;
    logic [11:0] bars[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};
    solid_a = 12'h123;
    tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0);
    void'(q_a.pop_front());
    void'(q_b.pop_front());
    // Frame 1 still uses the reset (solid) shadow, frame 2 is bars.
    for (int i = 0; i < 256; i++) begin
      tick(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
      e = q_a.pop_front();
      void'(q_b.pop_front());
      if (fs_a) frame++;
      n_checks++;
      if (act_a !== e) begin
        n_fail++;
        $display("FAIL bars_a cyc=%0d actual=%h expected=%h", cyc, act_a, e);
      end
      if (frame == 2 && y_a == 10'd1 && de_a) begin
        n_checks++;
        if ({r_a, g_a, b_a} !== bars[x_a[2:0]]) begin
          n_fail++;
          $display("FAIL bar_colour x=%0d actual=%h expected=%h", x_a, {r_a, g_a, b_a},
                   bars[x_a[2:0]]);
        end
      end
    end
  endtask

  task automatic test_mode_switch_a();
    out_t       e;
    logic [1:0] md = 2'd1;
    int         fs_after = 0;
    for (int i = 0; i < 384; i++) begin
      if (st_a.v == 2) md = 2'd2;
      tick(1'b0, 1'b1, md, 1'b0, 1'b0, 2'd0);
      e = q_a.pop_front();
      void'(q_b.pop_front());
      if (fs_a && md == 2'd2) fs_after++;
      n_checks++;
      if (act_a !== e) begin
        n_fail++;
        $display("FAIL mode_switch_a cyc=%0d actual=%h expected=%h", cyc, act_a, e);
      end
      // Switch frame: x=1,y=3 must still be yellow bar (checker would be white).
      if (md == 2'd2 && fs_after == 0 && x_a == 10'd1 && y_a == 10'd3) begin
        n_checks++;
        if ({r_a, g_a, b_a} !== 12'hFF0) begin
          n_fail++;
          $display("FAIL no_tear actual=%h expected=ff0", {r_a, g_a, b_a});
        end
      end
      // Next frame: x=2,y=0 is a white checker square (a bar would be cyan).
      if (fs_after == 1 && x_a == 10'd2 && y_a == 10'd0) begin
        n_checks++;
        if ({r_a, g_a, b_a} !== 12'hFFF) begin
          n_fail++;
          $display("FAIL checker_start actual=%h expected=fff", {r_a, g_a, b_a});
        end
      end
    end
  endtask

  task automatic test_pixen_b();
    out_t e;
    bit   en;
    int   hs_cnt = 0, vs_lines = 0, de_cnt = 0, last_fs = -1;
    solid_b = 12'h5A3;
    tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3);
    void'(q_a.pop_front());
    void'(q_b.pop_front());
    // 1-in-4 enable: frameStart every 4*2016 clocks; 2 frames + 1 pixel.
    for (int i = 0; i < 16129; i++) begin
      en = (i % 4 == 0);
      tick(1'b0, 1'b0, 2'd0, 1'b0, en, 2'd3);
      void'(q_a.pop_front());
      e = q_b.pop_front();
      n_checks++;
      if (act_b !== e) begin
        n_fail++;
        $display("FAIL pixen_b cyc=%0d actual=%h expected=%h", cyc, act_b, e);
      end
      if (en) begin
        if (hs_b) hs_cnt++;
        if (vs_b && ls_b) vs_lines++;
        if (de_b) de_cnt++;
        if (fs_b) begin
          if (last_fs >= 0) begin
            n_checks++;
            if (cyc - last_fs != 8064) begin
              n_fail++;
              $display("FAIL fs_period_b actual=%0d expected=8064", cyc - last_fs);
            end
          end
          last_fs = cyc;
        end
      end
    end
    n_checks++;
    if (hs_cnt != 576) begin
      n_fail++; $display("FAIL hsync_count_b actual=%0d expected=576", hs_cnt);
    end
    n_checks++;
    if (vs_lines != 4) begin
      n_fail++; $display("FAIL vsync_lines_b actual=%0d expected=4", vs_lines);
    end
    n_checks++;
    if (de_cnt != 2401) begin
      n_fail++; $display("FAIL de_count_b actual=%0d expected=2401", de_cnt);
    end
  endtask

  task automatic test_mid_reset_b();
    out_t e;
    bit   reached = 1'b0;
    tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2);
    void'(q_a.pop_front());
    void'(q_b.pop_front());
    for (int i = 0; i < 3000 && !reached; i++) begin
      tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2);
      void'(q_a.pop_front());
      e = q_b.pop_front();
      n_checks++;
      if (act_b !== e) begin
        n_fail++;
        $display("FAIL run_b cyc=%0d actual=%h expected=%h", cyc, act_b, e);
      end
      reached = (st_b.h == 30 && st_b.v == 20);
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL reach_mid_frame actual=%0d/%0d expected=30/20", st_b.h, st_b.v);
    end
    // One-clock reset with pixEn still high.
    tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2);
    void'(q_a.pop_front());
    e = q_b.pop_front();
    n_checks++;
    if (act_b !== e) begin
      n_fail++;
      $display("FAIL mid_reset_b actual=%h expected=%h", act_b, e);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2);
      void'(q_a.pop_front());
      e = q_b.pop_front();
      n_checks++;
      if (act_b !== e) begin
        n_fail++;
        $display("FAIL after_reset_b cyc=%0d actual=%h expected=%h", cyc, act_b, e);
      end
      if (i == 0) begin
        n_checks++;
        if (x_b !== 10'd0 || y_b !== 10'd0 || fs_b !== 1'b1 || de_b !== 1'b1) begin
          n_fail++;
          $display("FAIL restart_b actual=x%0d y%0d fs%b de%b expected=x0 y0 fs1 de1",
                   x_b, y_b, fs_b, de_b);
        end
      end
    end
  endtask

  initial begin
    cfg_a = '{hact: A_HA, hfp: A_HF, hs: A_HS, hbp: A_HB,
              vact: A_VA, vfp: A_VF, vs: A_VS, vbp: A_VB,
              hpol: 1'b0, vpol: 1'b0, barw: 1, chk: 1, grad: 0};
    cfg_b = '{hact: B_HA, hfp: B_HF, hs: B_HS, hbp: B_HB,
              vact: B_VA, vfp: B_VF, vs: B_VS, vbp: B_VB,
              hpol: 1'b1, vpol: 1'b1, barw: 5, chk: 2, grad: 2};
    st_a    = '{h: 0, v: 0, md: 0, last: '0};
    st_b    = '{h: 0, v: 0, md: 0, last: '0};
    solid_a = 12'h000;
    solid_b = 12'h000;
    test_reset();
    test_timing_a();
    test_bars_a();
    test_mode_switch_a();
    test_pixen_b();
    test_mid_reset_b();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
Parametrised successor to the fixed 640x480 clock/tracker/pattern chain. Generates the complete VGA raster from one pixel clock: h/v counters, sync pulses with configurable polarity, data-enable, and pixel coordinates. It also drives COLOR_W-bit RGB from four runtime-selectable test patterns. Sits between the clock generator's pixel clock output and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
COLOR_W, 4, bits per colour channel
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
BAR_W, 80, colour-bar width in pixels (>=1)
CHK_LOG2, 5, checkerboard square = 2^CHK_LOG2 pixels
GRAD_SHIFT, 4, gradient uses xCor[GRAD_SHIFT +: COLOR_W]

Ports:
pixelClk  in  1  pixel clock; sole clock
reset  in  1  synchronous, active-high reset
pixEn  in  1  pixel clock-enable; all state advances only when high
mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 gradient
solidRGB  in  3*COLOR_W  {R,G,B} colour for mode 0
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable (active video)
xCor  out  CNT_W  horizontal counter of the current output pixel
yCor  out  CNT_W  vertical counter of the current output pixel
lineStart  out  1  high for the output pixel at hcnt==0
frameStart  out  1  high for the output pixel at hcnt==0, vcnt==0
VGA_R, VGA_G, VGA_B  out  COLOR_W each  pixel colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hcnt runs 0..H_TOTAL-1 and wraps to 0. vcnt increments on the hcnt wrap and wraps after V_TOTAL-1. Both advance only on pixEn=1.
- Active region: hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- hsync is at the active level iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on vcnt; it is line-granular and changes with the hcnt=0 pixel.
- Latency: every output is registered and reflects the counter state of the previous enabled cycle. All outputs are mutually aligned and change only on pixEn cycles.
- Reset values:
  - hcnt=vcnt=0
  - hsync=~H_POL, vsync=~V_POL
  - de=0, lineStart=0, frameStart=0
  - xCor=yCor=0
  - RGB=0
  - mode shadow=0
- First enabled cycle after reset release: outputs show x=0, y=0, de=1, lineStart=1, frameStart=1.
- Reset mid-operation takes priority over pixEn and applies within one clock. No partial line or frame is resumed.
- Mode shadow: mode is sampled only on the enabled cycle where hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1. The new pattern takes effect from the next frameStart, so a frame never tears. solidRGB is sampled live.
- Bars: a bar counter is cleared at hcnt=0 and steps every BAR_W active pixels, saturating at 7. Colour order is white, yellow, cyan, green, magenta, red, blue, black. Each channel is either full-scale or 0.
- Checker: white if (x[CHK_LOG2] ^ y[CHK_LOG2]), else black.
- Gradient: R=G=B=x[GRAD_SHIFT +: COLOR_W].
- Outside the active region, RGB=0 regardless of mode.

Decomposition:
- Shared package vga_pkg holds:
  - mode enum (MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD)
  - 8-entry colour-bar constant table of 3-bit on/off masks
  - H_TOTAL/V_TOTAL helper functions
- One natural sub-module, vga_timing, holds the counters, sync/de decode and lineStart/frameStart. It is reusable without the pattern logic.
- Pattern mux and output registers live in the top.

Test Plan:
- Default params, pixEn=1, run 2 frames:
  - each line has 96 active-low hsync cycles at hcnt 656..751
  - 2 vsync lines at vcnt 490..491
  - 307200 de cycles per frame
  - frameStart period 420000 clocks
- pixEn high 1 of every 4 clocks:
  - outputs change only on enabled cycles
  - frameStart period 1,680,000 clocks
  - counts otherwise identical to the previous scenario
- Small params (H 8/2/3/3, V 4/1/2/1), BAR_W=1, mode=1:
  - x=0..7 yields RGB F/F/F, F/F/0, 0/F/F, 0/F/0, F/0/F, F/0/0, 0/0/F, 0/0/0
  - blanking pixels are 0
- Small params, switch mode 1->2 at y=2:
  - remaining pixels of the frame are still bars
  - the frame after the next frameStart is checkerboard
- Assert reset at x=300, y=100 for one clock:
  - next clock outputs hold reset values
  - after release, first enabled output is x=0, y=0, frameStart=1
- H_POL=1, V_POL=1: hsync/vsync high only during sync intervals and low at reset.
